// File: rtl/iic_pkg.sv
// Shared definitions for the IIC command sequencer: register map, command read flag and FSM states.
package iic_pkg;

  localparam logic [31:0] IIC_REG_DIV  = 32'h0000_0000;
  localparam logic [31:0] IIC_REG_SDIV = 32'h0000_0004;
  localparam logic [31:0] IIC_REG_CMD  = 32'h0000_0008;
  localparam logic [31:0] IIC_REG_DATA = 32'h0000_0010;
  localparam logic [31:0] IIC_REG_INT  = 32'h0000_0014;

  localparam int unsigned IIC_CMD_RD_BIT = 0;

  typedef enum logic [3:0] {
    INIT0 = 4'd0,
    INIT1 = 4'd1,
    INITC = 4'd2,
    IDLE  = 4'd3,
    CMD   = 4'd4,
    WDATA = 4'd5,
    WAIT  = 4'd6,
    RDATA = 4'd7,
    CLR   = 4'd8,
    RESP  = 4'd9
  } iic_seq_state_e;

  function automatic logic cmd_is_read(input logic [31:0] cmd);
    return cmd[IIC_CMD_RD_BIT];
  endfunction

endpackage

// File: rtl/iic_reg_access.sv
// Single register access engine: raises one strobe with addr/wdata, holds until iic_ready is
// sampled, drops it on the following cycle and reports completion with a combinational done pulse.
module iic_reg_access
  import iic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        iic_reg_wr_en,
  output logic        iic_reg_rd_en,
  output logic [31:0] iic_reg_addr,
  output logic [31:0] iic_reg_wdata,
  input  logic        iic_ready,
  input  logic [31:0] iic_reg_rdata
);

  logic        wr_en_r;
  logic        rd_en_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        busy_s;

  assign busy_s = wr_en_r | rd_en_r;

  // Done coincides with the edge that samples iic_ready, so the caller can start the next
  // access right after the single strobe-low cycle.
  assign busy = busy_s;
  assign done = busy_s & iic_ready;

  // Strobe/address/data hold and read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else if (busy_s) begin
      if (iic_ready) begin
        wr_en_r <= 1'b0;
        rd_en_r <= 1'b0;
        addr_r  <= 32'h0000_0000;
        wdata_r <= 32'h0000_0000;
        if (rd_en_r) begin
          rdata_r <= iic_reg_rdata;
        end
      end
    end else if (start) begin
      wr_en_r <= ~rw;
      rd_en_r <= rw;
      addr_r  <= addr;
      wdata_r <= rw ? 32'h0000_0000 : wdata;
    end
  end

  assign iic_reg_wr_en = wr_en_r;
  assign iic_reg_rd_en = rd_en_r;
  assign iic_reg_addr  = addr_r;
  assign iic_reg_wdata = wdata_r;
  assign rdata         = rdata_r;

endmodule

// File: rtl/iic_cmd_sequencer.sv
// Request/response front-end that walks iic_top's register port through init, command, data,
// completion wait, readback and interrupt clear. Optional completion timeout: IIC_SEQ_TIMEOUT_EN.
module iic_cmd_sequencer
  import iic_pkg::*;
#(
  parameter logic [31:0] SCL_DIV        = 32'd165,
  parameter logic [31:0] SAMPLE_DIV     = 32'd19,
  parameter logic [31:0] INT_CLR        = 32'h0000_0018,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_cmd,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iic_reg_wr_en,
  output logic        iic_reg_rd_en,
  output logic [31:0] iic_reg_addr,
  output logic [31:0] iic_reg_wdata,
  input  logic [31:0] iic_reg_rdata,
  input  logic        iic_ready,
  input  logic        data_ready_int,
  input  logic        write_ready_int
);

  iic_seq_state_e state_r, state_next_s;

  logic [31:0] cmd_r;
  logic [31:0] wdata_r;
  logic        err_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        is_rd_s;
  logic        int_hit_s;
  logic        tmo_s;
  logic        accept_s;

  logic        acc_start_s;
  logic        acc_rw_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic        acc_busy_s;
  logic        acc_done_s;
  logic [31:0] acc_rdata_s;

  assign is_rd_s   = cmd_is_read(cmd_r);
  assign int_hit_s = is_rd_s ? data_ready_int : write_ready_int;
  assign accept_s  = (state_r == IDLE) & req_valid & req_ready_r;

`ifdef IIC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt_r;

  // Cycles spent in WAIT; held at zero elsewhere so every entry starts a fresh count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r != WAIT) begin
      tmo_cnt_r <= 16'd0;
    end else if (tmo_cnt_r != TMO_LIMIT) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  assign tmo_s = (state_r == WAIT) && (tmo_cnt_r == TMO_LIMIT);
`else
  assign tmo_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= INIT0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing; access states advance on the engine's done pulse
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      INIT0: state_next_s = acc_done_s ? INIT1 : INIT0;
      INIT1: state_next_s = acc_done_s ? INITC : INIT1;
      INITC: state_next_s = acc_done_s ? IDLE  : INITC;
      IDLE:  state_next_s = accept_s   ? CMD   : IDLE;
      CMD: begin
        if (acc_done_s) begin
          state_next_s = is_rd_s ? WAIT : WDATA;
        end else begin
          state_next_s = CMD;
        end
      end
      WDATA: state_next_s = acc_done_s ? WAIT : WDATA;
      WAIT: begin
        if (int_hit_s) begin
          state_next_s = is_rd_s ? RDATA : CLR;
        end else if (tmo_s) begin
          state_next_s = CLR;
        end else begin
          state_next_s = WAIT;
        end
      end
      RDATA: state_next_s = acc_done_s ? CLR  : RDATA;
      CLR:   state_next_s = acc_done_s ? RESP : CLR;
      RESP:  state_next_s = rsp_ready  ? IDLE : RESP;
      default: state_next_s = INIT0;
    endcase
  end

  // Access request for the current state
  always_comb begin
    acc_start_s = 1'b0;
    acc_rw_s    = 1'b0;
    acc_addr_s  = 32'h0000_0000;
    acc_wdata_s = 32'h0000_0000;
    case (state_r)
      INIT0: begin
        acc_start_s = ~acc_busy_s;
        acc_addr_s  = IIC_REG_DIV;
        acc_wdata_s = SCL_DIV;
      end
      INIT1: begin
        acc_start_s = ~acc_busy_s;
        acc_addr_s  = IIC_REG_SDIV;
        acc_wdata_s = SAMPLE_DIV;
      end
      INITC, CLR: begin
        acc_start_s = ~acc_busy_s;
        acc_addr_s  = IIC_REG_INT;
        acc_wdata_s = INT_CLR;
      end
      CMD: begin
        acc_start_s = ~acc_busy_s;
        acc_addr_s  = IIC_REG_CMD;
        acc_wdata_s = cmd_r;
      end
      WDATA: begin
        acc_start_s = ~acc_busy_s;
        acc_addr_s  = IIC_REG_DATA;
        acc_wdata_s = wdata_r;
      end
      RDATA: begin
        acc_start_s = ~acc_busy_s;
        acc_rw_s    = 1'b1;
        acc_addr_s  = IIC_REG_DATA;
      end
      default: begin
        acc_start_s = 1'b0;
      end
    endcase
  end

  // Request latch and timeout flag for the transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r   <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      cmd_r   <= req_cmd;
      wdata_r <= req_wdata;
      err_r   <= 1'b0;
    end else if ((state_r == WAIT) && !int_hit_s && tmo_s) begin
      err_r   <= 1'b1;
    end
  end

  // Handshake outputs follow the next state; response payload loads only on RESP entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_next_s == IDLE);
      rsp_valid_r <= (state_next_s == RESP);
      if ((state_next_s == RESP) && (state_r != RESP)) begin
        rsp_rdata_r <= (is_rd_s && !err_r) ? acc_rdata_s : 32'h0000_0000;
        rsp_err_r   <= err_r;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  iic_reg_access u_reg_access (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (acc_start_s),
    .rw            (acc_rw_s),
    .addr          (acc_addr_s),
    .wdata         (acc_wdata_s),
    .busy          (acc_busy_s),
    .done          (acc_done_s),
    .rdata         (acc_rdata_s),
    .iic_reg_wr_en (iic_reg_wr_en),
    .iic_reg_rd_en (iic_reg_rd_en),
    .iic_reg_addr  (iic_reg_addr),
    .iic_reg_wdata (iic_reg_wdata),
    .iic_ready     (iic_ready),
    .iic_reg_rdata (iic_reg_rdata)
  );

endmodule

// File: doc/iic_cmd_sequencer.md
# iic_cmd_sequencer

Transaction front-end placed directly upstream of `iic_top`: accepts whole IIC read/write requests on a valid/ready port and drives `iic_top`'s register port (`iic_reg_*`) through the full access sequence. The sequence is program divider, issue command, push write data, wait for completion interrupt, fetch read data, acknowledge interrupt. It returns one response per request, so CPU-side logic never polls IIC registers directly.

## Interface
- `SCL_DIV`, 165: value written to reg 0x00 during init.
- `SAMPLE_DIV`, 19: value written to reg 0x04 during init.
- `INT_CLR`, 32'h18: value written to reg 0x14 to acknowledge an interrupt.
- `TIMEOUT_CYCLES`, 65535: completion-wait limit; 16-bit counter.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_cmd`  in  32  command word forwarded verbatim to reg 0x08; bit0 = 1 read, 0 write.
- `req_wdata`  in  32  write payload forwarded to reg 0x10; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  32  reg 0x10 value for reads; 0 for writes.
- `rsp_err`  out  1  completion timed out.
- `iic_reg_wr_en`, `iic_reg_rd_en`  out  1 each  register access strobes.
- `iic_reg_addr`, `iic_reg_wdata`  out  32 each  register address and data.
- `iic_reg_rdata`  in  32  register read data.
- `iic_ready`  in  1  access-complete handshake.
- `data_ready_int`, `write_ready_int`  in  1 each  read-done and write-done interrupts.

## Operation
- FSM states: `INIT0` → `INIT1` → `INITC` → `IDLE` → `CMD` → (write: `WDATA`) → `WAIT` → (read: `RDATA`) → `CLR` → `RESP` → `IDLE`.
- `INIT0`: write `SCL_DIV` to 0x00. `INIT1`: write `SAMPLE_DIV` to 0x04. `INITC`: write `INT_CLR` to 0x14. All three run once after each reset.
- `IDLE`: `req_ready`=1. On `req_valid && req_ready`, latch `req_cmd`/`req_wdata`, go to `CMD`.
- `CMD`: write latched command to 0x08. `WDATA` (write only): write latched data to 0x10.
- `WAIT`: read waits for `data_ready_int`, write waits for `write_ready_int`. The non-matching interrupt is ignored.
- `RDATA`: read 0x10 and capture `iic_reg_rdata` into `rsp_rdata`.
- `CLR`: write `INT_CLR` to 0x14. Runs on both success and timeout.
- `RESP`: `rsp_valid`=1, held with data stable until `rsp_ready`, then go to `IDLE`.
- Register access rule: assert strobe with addr/wdata and hold all three until a rising edge samples `iic_ready`=1. Deassert on the next cycle. Keep exactly one idle cycle (both strobes 0) before the next access. Never assert `wr_en` and `rd_en` together.

## Timing
- Reset values: all outputs 0; FSM = `INIT0`; timeout counter 0. Reset asserted mid-transaction aborts it with no response, and init reruns.
- Accept to `iic_reg_wr_en` (CMD) rising: 1 cycle.
- `req_ready` is 0 in every state except `IDLE`; there is no request buffering.
- Read capture happens on the edge where `iic_ready`=1 in `RDATA`.
- Response registers update only on entry to `RESP`.
- Interrupt already high on entry to `WAIT`: proceed on the next edge.
- `rsp_valid && rsp_ready` in the same cycle a new `req_valid` arrives: the request is accepted one cycle later, in `IDLE`.

## Configuration
- `IIC_SEQ_TIMEOUT_EN` defined:
  - `WAIT` counts cycles.
  - When the count reaches `TIMEOUT_CYCLES`, go to `CLR` with `rsp_err`=1 and `rsp_rdata`=0.
  - The counter clears on entering `WAIT`.
- Undefined: no counter, `rsp_err` tied 0, and `WAIT` holds indefinitely.

## Structure
- Shared package `iic_pkg`: register offsets (`IIC_REG_DIV`=0x00, `IIC_REG_SDIV`=0x04, `IIC_REG_CMD`=0x08, `IIC_REG_DATA`=0x10, `IIC_REG_INT`=0x14), the command-bit0 read flag, and the FSM state enum.
- One sub-module, `iic_reg_access`. It implements the strobe/hold/`iic_ready`/one-idle-cycle handshake, taking a start pulse with addr/wdata/rw and returning a done pulse and read data. The FSM only sequences it.

## Test plan
- Reset release → accesses in order: 0x00 = 165, 0x04 = 19, 0x14 = 0x18; `req_ready` rises only after the third completes.
- Read `req_cmd`=0x03010003; model raises `data_ready_int` and returns 0x0000000F on 0x10 → accesses 0x08 write, 0x10 read, 0x14 = 0x18; response `rsp_rdata`=0x0000000F, `rsp_err`=0.
- Write `req_cmd`=0x05040102, `req_wdata`=0x00080706 → 0x08 then 0x10 = 0x00080706. After `write_ready_int`, 0x14 = 0x18; response `rsp_rdata`=0.
- `rsp_ready` held low 10 cycles → `rsp_valid` and data stable; `req_ready`=0 throughout.
- `IIC_SEQ_TIMEOUT_EN` with `TIMEOUT_CYCLES`=100, no interrupt → response `rsp_err`=1 about 100 cycles after `WAIT` entry, preceded by the 0x14 clear.
- `rst_n` pulsed low during `WAIT` → all outputs 0 immediately, no response, init sequence repeats.
